// File: rtl/mux16_scan_ctrl.sv
// Scans a 16-bit word through an external 16:1 mux one select at a time,
// samples each result after HOLD cycles and reassembles it, flagging mismatches.
module mux16_scan_ctrl #(
  parameter int unsigned HOLD = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [0:15] load_data,
  output logic [0:15] mux_in,
  output logic [0:3]  mux_sel,
  input  logic        mux_out,
  output logic        bit_valid,
  output logic        bit_data,
  output logic [0:3]  bit_idx,
  output logic [0:15] rx_word,
  output logic        done,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } state_t;

  localparam logic [2:0] HOLD_LAST = 3'(HOLD - 1);

  state_t      state_q, state_d;
  logic [0:15] mux_in_q, mux_in_d;
  logic [0:3]  mux_sel_q, mux_sel_d;
  logic [2:0]  hold_q, hold_d;
  logic        bit_valid_q, bit_valid_d;
  logic        bit_data_q, bit_data_d;
  logic [0:3]  bit_idx_q, bit_idx_d;
  logic [0:15] rx_word_q, rx_word_d;
  logic        err_q, err_d;

  logic accept;
  logic sample;
  logic last_sel;

  assign accept   = (state_q == IDLE) && load_valid;
  assign sample   = (state_q == SCAN) && (hold_q == HOLD_LAST);
  assign last_sel = (mux_sel_q == 4'd15);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = SCAN;
      SCAN: if (sample && last_sel) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    load_ready = (state_q == IDLE) && !reset;
    done       = (state_q == DONE);
    busy       = (state_q == SCAN) || (state_q == DONE);
  end

  // Sample results are registered, so each strobe, rx_word bit and err update
  // becomes visible the cycle after its sample cycle.
  always_comb begin
    mux_in_d    = mux_in_q;
    mux_sel_d   = mux_sel_q;
    hold_d      = hold_q;
    bit_valid_d = 1'b0;
    bit_data_d  = bit_data_q;
    bit_idx_d   = bit_idx_q;
    rx_word_d   = rx_word_q;
    err_d       = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          mux_in_d  = load_data;
          mux_sel_d = '0;
          hold_d    = '0;
          rx_word_d = '0;
          err_d     = 1'b0;
        end
      end
      SCAN: begin
        if (sample) begin
          bit_valid_d          = 1'b1;
          bit_data_d           = mux_out;
          bit_idx_d            = mux_sel_q;
          rx_word_d[mux_sel_q] = mux_out;
          if (mux_out != mux_in_q[mux_sel_q]) err_d = 1'b1;
          hold_d = '0;
          if (!last_sel) mux_sel_d = mux_sel_q + 4'd1;
        end else begin
          hold_d = hold_q + 3'd1;
        end
      end
      DONE: begin
        mux_sel_d = '0;
        hold_d    = '0;
      end
      default: begin
        mux_sel_d = '0;
        hold_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mux_in_q    <= '0;
      mux_sel_q   <= '0;
      hold_q      <= '0;
      bit_valid_q <= 1'b0;
      bit_data_q  <= 1'b0;
      bit_idx_q   <= '0;
      rx_word_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      mux_in_q    <= mux_in_d;
      mux_sel_q   <= mux_sel_d;
      hold_q      <= hold_d;
      bit_valid_q <= bit_valid_d;
      bit_data_q  <= bit_data_d;
      bit_idx_q   <= bit_idx_d;
      rx_word_q   <= rx_word_d;
      err_q       <= err_d;
    end
  end

  assign mux_in    = mux_in_q;
  assign mux_sel   = mux_sel_q;
  assign bit_valid = bit_valid_q;
  assign bit_data  = bit_data_q;
  assign bit_idx   = bit_idx_q;
  assign rx_word   = rx_word_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Bench for mux16_scan_ctrl: HOLD=1 and HOLD=3 instances share stimulus and are
// checked every cycle against a timing model derived from accept time.
module tb_mux16_scan_ctrl;

  localparam int unsigned H0 = 1;
  localparam int unsigned H1 = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_valid;
  logic [0:15] load_data;
  logic        load_ready [2];
  logic [0:15] mux_in     [2];
  logic [0:3]  mux_sel    [2];
  logic        mux_out    [2];
  logic        bit_valid  [2];
  logic        bit_data   [2];
  logic [0:3]  bit_idx    [2];
  logic [0:15] rx_word    [2];
  logic        done       [2];
  logic        err        [2];
  logic        busy       [2];

  int stuck  = -1;
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  bit          model_valid = 1'b0;
  bit          m_active [2];
  int          m_age    [2];
  logic [0:15] m_word   [2];
  int          m_stuck  [2];
  logic [0:15] m_rx     [2];
  logic        m_err    [2];
  logic [0:15] m_muxin  [2];
  bit          m_jrst   [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux16_scan_ctrl #(.HOLD(H0)) u_h1 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready[0]),
    .load_data(load_data), .mux_in(mux_in[0]), .mux_sel(mux_sel[0]), .mux_out(mux_out[0]),
    .bit_valid(bit_valid[0]), .bit_data(bit_data[0]), .bit_idx(bit_idx[0]),
    .rx_word(rx_word[0]), .done(done[0]), .err(err[0]), .busy(busy[0])
  );

  mux16_scan_ctrl #(.HOLD(H1)) u_h3 (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready[1]),
    .load_data(load_data), .mux_in(mux_in[1]), .mux_sel(mux_sel[1]), .mux_out(mux_out[1]),
    .bit_valid(bit_valid[1]), .bit_data(bit_data[1]), .bit_idx(bit_idx[1]),
    .rx_word(rx_word[1]), .done(done[1]), .err(err[1]), .busy(busy[1])
  );

  // External 16:1 mux, optionally stuck at 0 on one select
  assign mux_out[0] = (int'(mux_sel[0]) == stuck) ? 1'b0 : mux_in[0][mux_sel[0]];
  assign mux_out[1] = (int'(mux_sel[1]) == stuck) ? 1'b0 : mux_in[1][mux_sel[1]];

  function automatic int hold_of(int i);
    return (i == 0) ? int'(H0) : int'(H1);
  endfunction

  function automatic logic samp(logic [0:15] w, int st, int k);
    return (k == st) ? 1'b0 : w[k];
  endfunction

  // Bit k is reported at age 1+H*(k+1) after the accept cycle
  function automatic logic [0:15] exp_rx(logic [0:15] w, int st, int a, int h);
    logic [0:15] r = '0;
    for (int k = 0; k < 16; k++)
      if (1 + h * (k + 1) <= a) r[k] = samp(w, st, k);
    return r;
  endfunction

  function automatic logic exp_err(logic [0:15] w, int st, int a, int h);
    logic e = 1'b0;
    for (int k = 0; k < 16; k++)
      if (1 + h * (k + 1) <= a && samp(w, st, k) != w[k]) e = 1'b1;
    return e;
  endfunction

  task automatic chk(string name, int inst, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s u%0d cyc=%0d actual=%0h required=%0h", name, inst, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int a, hh, k;
    for (int i = 0; i < 2; i++) begin
      if (model_valid) begin
        a  = m_age[i];
        hh = hold_of(i);
        if (m_active[i]) begin
          chk("load_ready", i, load_ready[i], 0);
          chk("busy", i, busy[i], 1);
          chk("done", i, done[i], (a == 1 + 16 * hh));
          chk("bit_valid", i, bit_valid[i], (a - 1 >= hh) && ((a - 1) % hh == 0));
          if ((a - 1 >= hh) && ((a - 1) % hh == 0)) begin
            k = (a - 1) / hh - 1;
            chk("bit_idx", i, bit_idx[i], k);
            chk("bit_data", i, bit_data[i], samp(m_word[i], m_stuck[i], k));
          end
          chk("rx_word", i, rx_word[i], exp_rx(m_word[i], m_stuck[i], a, hh));
          chk("err", i, err[i], exp_err(m_word[i], m_stuck[i], a, hh));
          chk("mux_in", i, mux_in[i], m_word[i]);
          chk("mux_sel", i, mux_sel[i], ((a - 1) / hh > 15) ? 15 : (a - 1) / hh);
        end else begin
          chk("load_ready", i, load_ready[i], !reset);
          chk("busy", i, busy[i], 0);
          chk("done", i, done[i], 0);
          chk("bit_valid", i, bit_valid[i], 0);
          chk("rx_word", i, rx_word[i], m_rx[i]);
          chk("err", i, err[i], m_err[i]);
          chk("mux_in", i, mux_in[i], m_muxin[i]);
          chk("mux_sel", i, mux_sel[i], 0);
        end
        if (m_jrst[i]) begin
          chk("bit_data_rst", i, bit_data[i], 0);
          chk("bit_idx_rst", i, bit_idx[i], 0);
        end
      end
      hh = hold_of(i);
      if (reset) begin
        m_active[i] <= 1'b0;
        m_age[i]    <= 0;
        m_rx[i]     <= '0;
        m_err[i]    <= 1'b0;
        m_muxin[i]  <= '0;
        m_jrst[i]   <= 1'b1;
      end else begin
        m_jrst[i] <= 1'b0;
        if (m_active[i]) begin
          if (m_age[i] == 1 + 16 * hh) begin
            m_active[i] <= 1'b0;
            m_rx[i]     <= exp_rx(m_word[i], m_stuck[i], m_age[i], hh);
            m_err[i]    <= exp_err(m_word[i], m_stuck[i], m_age[i], hh);
            m_muxin[i]  <= m_word[i];
          end else begin
            m_age[i] <= m_age[i] + 1;
          end
        end else if (load_valid) begin
          m_active[i] <= 1'b1;
          m_age[i]    <= 1;
          m_word[i]   <= load_data;
          m_stuck[i]  <= stuck;
        end
      end
    end
    model_valid <= 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(int inst);
    int n = 0;
    while (m_active[inst] && n < 300) begin
      tick();
      n++;
    end
    chk("idle_wait", inst, m_active[inst], 0);
  endtask

  task automatic scan_word(int inst, logic [0:15] w, output int lat);
    wait_idle(inst);
    load_valid = 1'b1;
    load_data  = w;
    tick();
    load_valid = 1'b0;
    lat = 1;
    while (done[inst] !== 1'b1 && lat < 400) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          lat, prev_t;
    logic [0:15] w, prev_w;
    reset      = 1'b1;
    load_valid = 1'b0;
    load_data  = '0;
    repeat (3) tick();
    reset = 1'b0;
    #1;
    chk("post_reset_ready", 0, load_ready[0], 1);
    chk("post_reset_rx", 0, rx_word[0], 16'h0000);
    chk("post_reset_busy", 1, busy[1], 0);

    // single set bit, ideal mux
    scan_word(0, 16'h8000, lat);
    chk("latency_h1", 0, lat, 17);
    tick();
    chk("onehot_rx", 0, rx_word[0], 16'h8000);
    chk("onehot_err", 0, err[0], 0);
    chk("onehot_ready", 0, load_ready[0], 1);

    // back-to-back one-hot words with load_valid held high
    wait_idle(0);
    load_valid = 1'b1;
    prev_t = -1;
    prev_w = '0;
    for (int k = 0; k < 16; k++) begin
      w = 16'h8000 >> k;
      load_data = w;
      for (int n = 0; m_active[0] && n < 100; n++) tick();
      if (prev_t >= 0) begin
        chk("b2b_gap", 0, cyc - prev_t, 18);
        chk("b2b_rx", 0, rx_word[0], prev_w);
      end
      prev_t = cyc;
      prev_w = w;
      tick();
    end
    load_valid = 1'b0;
    wait_idle(0);
    chk("b2b_last_rx", 0, rx_word[0], 16'h0001);

    // mux stuck at 0 on select 5
    wait_idle(0);
    wait_idle(1);
    stuck = 5;
    scan_word(0, 16'hFFFF, lat);
    tick();
    chk("stuck_rx", 0, rx_word[0], 16'hFBFF);
    chk("stuck_err", 0, err[0], 1);
    repeat (3) tick();
    chk("stuck_err_hold", 0, err[0], 1);
    wait_idle(0);
    wait_idle(1);
    stuck = -1;
    scan_word(0, 16'h1234, lat);
    tick();
    chk("err_cleared", 0, err[0], 0);

    // HOLD=3 latency
    scan_word(1, 16'hA5A5, lat);
    chk("latency_h3", 1, lat, 49);
    tick();
    chk("h3_rx", 1, rx_word[1], 16'hA5A5);

    // reset while select 7 is on the mux
    wait_idle(0);
    load_valid = 1'b1;
    load_data  = 16'h3C5A;
    tick();
    load_valid = 1'b0;
    for (int n = 0; mux_sel[0] !== 4'd7 && n < 100; n++) tick();
    chk("sel7_reached", 0, mux_sel[0], 7);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("abort_busy", 0, busy[0], 0);
    chk("abort_done", 0, done[0], 0);
    chk("abort_bv", 0, bit_valid[0], 0);
    chk("abort_rx", 0, rx_word[0], 16'h0000);
    chk("abort_muxin", 0, mux_in[0], 16'h0000);
    chk("abort_sel", 0, mux_sel[0], 0);
    chk("abort_ready", 0, load_ready[0], 1);

    // load_valid during a scan is ignored
    wait_idle(0);
    load_valid = 1'b1;
    load_data  = 16'h00FF;
    tick();
    load_valid = 1'b0;
    repeat (4) tick();
    load_valid = 1'b1;
    load_data  = 16'h0F0F;
    tick();
    load_valid = 1'b0;
    chk("ignore_muxin", 0, mux_in[0], 16'h00FF);
    wait_idle(0);
    chk("ignore_rx", 0, rx_word[0], 16'h00FF);

    // randomized traffic with occasional resets and stuck selects
    for (int c = 0; c < 1500; c++) begin
      if (!m_active[0] && !m_active[1] && $urandom_range(0, 7) == 0)
        stuck = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : -1;
      load_valid = 1'($urandom_range(0, 1));
      load_data  = 16'($urandom);
      reset      = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset      = 1'b0;
    load_valid = 1'b0;
    wait_idle(0);
    wait_idle(1);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
